// File: rtl/regfile_pkg.sv
// Shared widths, index/data types and the grant encoding used by the
// register-file writeback arbiter and its pending-load scoreboard.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int REGIDX_W = 5;

  typedef logic [REGIDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]     xdata_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_EX,
    GNT_LD
  } gnt_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load bitmap: loads set a bit at issue and clear it when their
// writeback commits; a new issue wins over a same-cycle clear.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            set_i,
  input  reg_idx_t        set_rd_i,
  input  logic            clr_i,
  input  reg_idx_t        clr_rd_i,
  input  logic            ld_xfer_i,
  input  reg_idx_t        ld_xfer_rd_i,
  input  reg_idx_t        rs1_i,
  input  reg_idx_t        rs2_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic [NREG-1:0] busy_o,
  output logic            sb_err_o
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;
  logic            set_nz;

  assign set_nz = set_i && (set_rd_i != '0);

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_rd_i] = 1'b0;
    if (set_nz) busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    // Double issue to a pending register, or a load returning with no
    // matching issue, both indicate a broken memory-side protocol.
    err_d = err_q
          | (set_nz && busy_q[set_rd_i])
          | (ld_xfer_i && (ld_xfer_rd_i != '0) && !busy_q[ld_xfer_rd_i]);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_i];
  assign rs2_busy_o = busy_q[rs2_i];
  assign busy_o     = busy_q;
  assign sb_err_o   = err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between execute results
// and load returns, with execute starvation relief and a registered commit.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     ex_valid_i,
  output logic     ex_ready_o,
  input  reg_idx_t ex_rd_i,
  input  xdata_t   ex_data_i,
  input  logic     ld_valid_i,
  output logic     ld_ready_o,
  input  reg_idx_t ld_rd_i,
  input  xdata_t   ld_data_i,
  input  logic     ld_issue_i,
  input  reg_idx_t ld_issue_rd_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  output logic     rs1_busy_o,
  output logic     rs2_busy_o,
  output logic     wr_req_o,
  output reg_idx_t rd_o,
  output xdata_t   wr_data_o,
  output logic     sb_err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [NREG-1:0] busy;
  logic            ex_nz, ld_nz, ex_elig, ld_elig;
  gnt_e            gnt;
  logic [SW-1:0]   starve_q, starve_d;
  logic            wr_req_q, wr_req_d;
  reg_idx_t        rd_q, rd_d;
  xdata_t          data_q, data_d;
  logic            is_load_q, is_load_d;

  assign ex_nz   = (ex_rd_i != '0);
  assign ld_nz   = (ld_rd_i != '0);
  // Execute is held behind an outstanding load to the same register (WAW).
  assign ex_elig = ex_valid_i && ex_nz && !busy[ex_rd_i];
  assign ld_elig = ld_valid_i && ld_nz;

  always_comb begin
    gnt = GNT_NONE;
    if (ex_elig && ld_elig) gnt = (starve_q == STARVE_MAX) ? GNT_EX : GNT_LD;
    else if (ex_elig)       gnt = GNT_EX;
    else if (ld_elig)       gnt = GNT_LD;
  end

  assign ex_ready_o = !ex_nz || (gnt == GNT_EX);
  assign ld_ready_o = !ld_nz || (gnt == GNT_LD);

  always_comb begin
    starve_d = starve_q;
    if ((gnt == GNT_EX) || !ex_valid_i)         starve_d = '0;
    else if (ex_elig && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
  end

  always_comb begin
    wr_req_d  = (gnt != GNT_NONE);
    is_load_d = (gnt == GNT_LD);
    rd_d      = rd_q;
    data_d    = data_q;
    case (gnt)
      GNT_EX: begin
        rd_d   = ex_rd_i;
        data_d = ex_data_i;
      end
      GNT_LD: begin
        rd_d   = ld_rd_i;
        data_d = ld_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      starve_q  <= '0;
      wr_req_q  <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      is_load_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      wr_req_q  <= wr_req_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      is_load_q <= is_load_d;
    end
  end

  regfile_scoreboard u_sb (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .set_i        (ld_issue_i),
    .set_rd_i     (ld_issue_rd_i),
    .clr_i        (wr_req_q && is_load_q),
    .clr_rd_i     (rd_q),
    .ld_xfer_i    (gnt == GNT_LD),
    .ld_xfer_rd_i (ld_rd_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .rs1_busy_o   (rs1_busy_o),
    .rs2_busy_o   (rs2_busy_o),
    .busy_o       (busy),
    .sb_err_o     (sb_err_o)
  );

  assign wr_req_o  = wr_req_q;
  assign rd_o      = rd_q;
  assign wr_data_o = data_q;

endmodule
